// File: rtl/mpc_pkg.sv
// Shared state encoding, default geometry/timing constants and the jump-arc helper
// for the multi-player move/jump controller.
package mpc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    JUMP  = 2'd2,
    SLIDE = 2'd3
  } state_t;

  localparam int DEF_NUM_PLAYERS  = 4;
  localparam int DEF_COORD_W      = 10;
  localparam int DEF_START_X      = 20;
  localparam int DEF_BASE_Y       = 124;
  localparam int DEF_FLAG_X       = 620;
  localparam int DEF_FLAG_TOP_Y   = 90;
  localparam int DEF_MOVE_FRAMES  = 24;
  localparam int DEF_JUMP_FRAMES  = 16;
  localparam int DEF_JUMP_HEIGHT  = 30;
  localparam int DEF_SLIDE_FRAMES = 20;

  // Height above ground for frame cnt of a symmetric triangular jump arc.
  function automatic int jump_offset(input int cnt, input int frames, input int height);
    int tri_cnt;
    if (cnt <= frames / 2) begin
      tri_cnt = cnt;
    end else begin
      tri_cnt = frames - cnt;
    end
    return (height * tri_cnt) / (frames / 2);
  endfunction

endpackage

// File: rtl/multi_player_controller_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting player at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int IW   = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx
);

  int idx;

  // Scan from the farthest candidate back to ptr so the closest request wins.
  always_comb begin
    any       = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        any           = 1'b1;
        grant_oh      = '0;
        grant_oh[idx] = 1'b1;
        grant_idx     = IW'(idx);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/multi_player_controller.sv
// Turn-based N-player sprite controller: move, jump and (with FLAG_SLIDE_EN defined)
// a flag slide, paced by frame_tick, with round-robin service of pending move requests.
module multi_player_controller
  import mpc_pkg::*;
#(
  parameter  int NUM_PLAYERS  = DEF_NUM_PLAYERS,
  parameter  int COORD_W      = DEF_COORD_W,
  parameter  int START_X      = DEF_START_X,
  parameter  int BASE_Y       = DEF_BASE_Y,
  parameter  int FLAG_X       = DEF_FLAG_X,
  parameter  int FLAG_TOP_Y   = DEF_FLAG_TOP_Y,
  parameter  int MOVE_FRAMES  = DEF_MOVE_FRAMES,
  parameter  int JUMP_FRAMES  = DEF_JUMP_FRAMES,
  parameter  int JUMP_HEIGHT  = DEF_JUMP_HEIGHT,
  parameter  int SLIDE_FRAMES = DEF_SLIDE_FRAMES,
  localparam int IDX_W        = $clog2(NUM_PLAYERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic [NUM_PLAYERS-1:0]         move_req,
  input  logic [NUM_PLAYERS*COORD_W-1:0] target_x,
  output logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
  output logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
  output logic [NUM_PLAYERS-1:0]         turn_done,
  output logic                           busy,
  output logic [IDX_W-1:0]               active_player
);

  localparam int MAX_FR1 = (MOVE_FRAMES > JUMP_FRAMES) ? MOVE_FRAMES : JUMP_FRAMES;
  localparam int MAX_FR  = (MAX_FR1 > SLIDE_FRAMES) ? MAX_FR1 : SLIDE_FRAMES;
  localparam int CNT_W   = $clog2(MAX_FR + 1);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || MOVE_FRAMES < 1 || JUMP_FRAMES < 2 ||
      (JUMP_FRAMES % 2) != 0 || SLIDE_FRAMES < 1 || FLAG_TOP_Y > BASE_Y ||
      JUMP_HEIGHT > BASE_Y || FLAG_X >= (1 << COORD_W)) begin : g_bad_cfg
    $error("multi_player_controller: illegal parameter set");
  end

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx, cnt_inc;
  logic [NUM_PLAYERS-1:0] req_q, pending, rise, grant_oh;
  logic [IDX_W-1:0]     rr_ptr, grant_idx;
  logic                 grant_any, grant, done_nx, upd_x, upd_y;
  logic [COORD_W-1:0]   start_x, tgt_x, new_x, new_y;
  logic [COORD_W-1:0]   xs [NUM_PLAYERS];
  logic [COORD_W-1:0]   ys [NUM_PLAYERS];
  int                   delta;

  assign rise    = move_req & ~req_q;
  assign cnt_inc = cnt + CNT_W'(1);
  assign busy    = (state != IDLE);

  rr_arbiter #(.N(NUM_PLAYERS)) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .any       (grant_any),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  // Flatten stored per-player coordinates onto the packed output buses.
  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      pos_x[i*COORD_W +: COORD_W] = xs[i];
      pos_y[i*COORD_W +: COORD_W] = ys[i];
    end
  end

  // Next state; positions are evaluated at the post-tick count so the last frame lands exactly.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant    = 1'b0;
    done_nx  = 1'b0;
    upd_x    = 1'b0;
    upd_y    = 1'b0;
    delta    = int'(tgt_x) - int'(start_x);
    new_x    = COORD_W'(int'(start_x) + (delta * int'(cnt_inc)) / MOVE_FRAMES);
    new_y    = COORD_W'(BASE_Y - jump_offset(int'(cnt_inc), JUMP_FRAMES, JUMP_HEIGHT));
    case (state)
      IDLE: begin
        if (grant_any) begin
          grant    = 1'b1;
          state_nx = MOVE;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      MOVE: begin
        if (frame_tick) begin
          upd_x = 1'b1;
          if (cnt == CNT_W'(MOVE_FRAMES - 1)) begin
            state_nx = JUMP;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
          state_nx = MOVE;
        end
      end
      JUMP: begin
        if (frame_tick) begin
          upd_y = 1'b1;
          if (cnt == CNT_W'(JUMP_FRAMES - 1)) begin
            cnt_nx = '0;
`ifdef FLAG_SLIDE_EN
            if (tgt_x == COORD_W'(FLAG_X)) begin
              state_nx = SLIDE;
              new_y    = COORD_W'(FLAG_TOP_Y);
            end else begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
`else
            state_nx = IDLE;
            done_nx  = 1'b1;
`endif
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
          state_nx = JUMP;
        end
      end
`ifdef FLAG_SLIDE_EN
      SLIDE: begin
        if (frame_tick) begin
          upd_y = 1'b1;
          new_y = COORD_W'(FLAG_TOP_Y + ((BASE_Y - FLAG_TOP_Y) * int'(cnt_inc)) / SLIDE_FRAMES);
          if (cnt == CNT_W'(SLIDE_FRAMES - 1)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
          state_nx = SLIDE;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, request capture, grant bookkeeping and the per-player position store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      req_q         <= '0;
      pending       <= '0;
      rr_ptr        <= '0;
      active_player <= '0;
      start_x       <= COORD_W'(START_X);
      tgt_x         <= COORD_W'(START_X);
      turn_done     <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        xs[i] <= COORD_W'(START_X);
        ys[i] <= COORD_W'(BASE_Y);
      end
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_q     <= move_req;
      pending   <= (pending & ~(grant_oh & {NUM_PLAYERS{grant}})) | rise;
      turn_done <= '0;
      if (done_nx) begin
        turn_done[active_player] <= 1'b1;
      end
      if (grant) begin
        active_player <= grant_idx;
        start_x       <= xs[grant_idx];
        tgt_x         <= target_x[grant_idx*COORD_W +: COORD_W];
        rr_ptr        <= (grant_idx == IDX_W'(NUM_PLAYERS - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      if (upd_x) begin
        xs[active_player] <= new_x;
      end
      if (upd_y) begin
        ys[active_player] <= new_y;
      end
    end
  end

endmodule

// File: doc/multi_player_controller.md
Name: multi_player_controller

Overview:
- Parametrised successor of the two-player move/jump controller: N players, one animating at a time (turn-based).
- Sits between game-logic (targets, move requests) and ui_render sprite drawing (per-player x/y).
- Adds: N players, frame-tick pacing, pending-request capture with round-robin arbitration, bidirectional moves, busy/active-player status.

Parameters:
- NUM_PLAYERS, 4, number of players (2..8)
- COORD_W, 10, x/y coordinate width
- START_X, 20, reset x of every player
- BASE_Y, 124, ground y
- FLAG_X, 620, x that triggers flag slide
- FLAG_TOP_Y, 90, slide start y
- MOVE_FRAMES, 24, frames of horizontal move (>=1)
- JUMP_FRAMES, 16, frames of jump (even, >=2)
- JUMP_HEIGHT, 30, jump apex in pixels
- SLIDE_FRAMES, 20, frames of flag slide (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per video frame; animation advances only on it
- move_req  in  NUM_PLAYERS  per-player level request; rising edge = new move
- target_x  in  NUM_PLAYERS*COORD_W  packed targets, player i at [i*COORD_W +: COORD_W]
- pos_x  out  NUM_PLAYERS*COORD_W  packed current x
- pos_y  out  NUM_PLAYERS*COORD_W  packed current y
- turn_done  out  NUM_PLAYERS  one-cycle pulse per finished turn
- busy  out  1  high whenever state != IDLE
- active_player  out  $clog2(NUM_PLAYERS)  player being animated (last one when IDLE)

Behaviour:
- Reset (synchronous, active-high, rst dominates): state IDLE, cnt 0, all pos_x = START_X, pos_y = BASE_Y, pending 0, turn_done 0, busy 0, active_player 0, round-robin pointer 0. A reset mid-animation abandons the move; no turn_done.
- Edge detect: move_req registered each clk; a rising edge sets pending[i]. It stays set until granted; repeat edges while pending are merged.
- Target capture: target_x[i] is sampled at grant, not at the edge.
- Arbitration in IDLE: if any pending bit is set, grant the first set bit at or after rr_ptr (wrapping). The same clk loads start_x, tgt_x and active_player, clears pending[grant], sets rr_ptr = grant+1 mod N, and enters MOVE with cnt = 0. Grant does not wait for frame_tick. Latency from edge to MOVE is 2 clk.
- States: IDLE -> MOVE -> JUMP -> (SLIDE) -> IDLE. cnt increments only on frame_tick.
  - MOVE: on the tick with cnt == MOVE_FRAMES-1, commit x = tgt_x, cnt 0, go to JUMP.
  - JUMP: on the tick with cnt == JUMP_FRAMES-1, go to SLIDE if tgt_x == FLAG_X (feature on), else IDLE.
  - SLIDE: on the tick with cnt == SLIDE_FRAMES-1, go to IDLE.
- Move arithmetic: delta = tgt_x - start_x, signed COORD_W+1 bits. x = start_x + (delta*cnt)/MOVE_FRAMES with signed truncation toward zero. Backward moves are legal. If tgt_x == start_x, x is held but the move still takes the full MOVE_FRAMES.
- Jump arithmetic: tri = cnt if cnt <= JUMP_FRAMES/2, else JUMP_FRAMES-cnt. y = BASE_Y - (JUMP_HEIGHT*tri)/(JUMP_FRAMES/2). Apex is exactly JUMP_HEIGHT at cnt = JUMP_FRAMES/2.
- Slide arithmetic: y = FLAG_TOP_Y + ((BASE_Y-FLAG_TOP_Y)*cnt)/SLIDE_FRAMES. Stored y returns to BASE_Y on exit.
- Outputs: all position outputs are registered. Non-active players hold their stored x/y.
- turn_done[active] pulses exactly one clk, registered, in the cycle after the transition into IDLE. A new grant may occur in that same cycle.
- Simultaneous events:
  - Edges from several players in one clk all set pending.
  - An edge from the active player during its own animation sets pending and is served on a later grant.
  - frame_tick and grant in the same clk: the grant wins and cnt stays 0.

Optional Feature:
- FLAG_SLIDE_EN defined: FLAG_X detection and the SLIDE state are present as described.
- Undefined: SLIDE is removed; JUMP always returns to IDLE and turn_done fires after the jump regardless of tgt_x.

Decomposition:
- Package mpc_pkg: state_t enum (IDLE, MOVE, JUMP, SLIDE), default coordinate/frame constants, and a function computing the jump offset.
- Sub-module rr_arbiter (NUM_PLAYERS requests, pointer in, one-hot/index grant out), instanced once.

Test Plan:
- Reset then idle 10 frames -> every pos_x = 20, pos_y = 124, busy 0, turn_done 0.
- P0 target 80, one edge, ticks every 4 clk -> x steps 20 to 80 over 24 ticks; y apex 94 at jump tick 8; turn_done[0] pulses once; x stays 80.
- P2 at 200, target 140 -> x decreases monotonically to 140, never below it; no underflow.
- Edges on P1, P2, P3 in the same clk with rr_ptr = 2 -> grant order P2, P3, P1; three turn_done pulses in that order; none lost.
- P1 target 620 with FLAG_SLIDE_EN -> jump then y 90 to 124 over 20 ticks, turn_done after slide. Without the macro -> turn_done right after the jump and y stays 124.
- rst asserted mid-JUMP -> next clk all players at (20,124), busy 0, pending cleared, no turn_done.
